acca_seq_ctrl: RTL and testbench
================================

ACCA_SEQ_CTRL -- requirements
Module: acca_seq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous reset, active-high.
REQ-003 SHALL have ports: in_valid  in  1  operand pair offered; in_ready  out  1  controller accepts operands.
REQ-004 SHALL have ports: a  in  8  multiplicand; b  in  8  multiplier; both captured on in_valid&&in_ready.
REQ-005 SHALL have ports: nib_a  out  4  nibble operand A; nib_b  out  4  nibble operand B; nib_sel  out  2  partial-product index for the external 4x4 unit (0=LL, 1=LH, 2=HL, 3=HH).
REQ-006 SHALL have ports: nib_p  in  8  product returned combinationally by the shared external 4x4 approximate multiplier in the same cycle.
REQ-007 SHALL have ports: out_valid  out  1  result available; out_ready  in  1  consumer accepts; prod  out  16  accumulated product.
REQ-008 SHALL have ports: busy  out  1  high in any state other than IDLE.

Function
REQ-009 SHALL implement states IDLE, LL, LH, HL, HH, DONE; one-hot or binary encoding is free.
REQ-010 in_ready SHALL equal (state==IDLE); acceptance registers a, b and clears the accumulator, next state LL.
REQ-011 Per state, nib_a/nib_b SHALL be: LL al/bl, LH al/bh, HL ah/bl, HH ah/bh (al=a[3:0], ah=a[7:4] of the captured operand; same for b); in IDLE and DONE nib_a=nib_b=0, nib_sel=0.
REQ-012 Each of LL, LH, HL, HH SHALL last exactly one cycle and add nib_p shifted left by 0, 4, 4, 8 respectively into the 16-bit accumulator.
REQ-013 Accumulation SHALL be modulo 2^16; carries beyond bit 15 are discarded (possible with approximate nib_p up to 255).
REQ-014 Transitions SHALL be LL->LH->HL->HH->DONE unconditionally (macro off).
REQ-015 Latency: acceptance at edge N; out_valid SHALL rise after edge N+4 (5 cycles accept-to-valid-inclusive), prod = final accumulator.
REQ-016 In DONE, out_valid=1 and prod SHALL hold stable until out_valid&&out_ready; then next state IDLE, out_valid=0 next cycle.
REQ-017 in_valid while not IDLE SHALL be ignored; a/b changes mid-operation SHALL not affect the result.
REQ-018 out_ready outside DONE SHALL have no effect; a new operand SHALL not be accepted in the same cycle a result is consumed (one idle cycle between operations).
REQ-019 nib_p SHALL be sampled only in LL/LH/HL/HH states.

Reset
REQ-020 rst high SHALL immediately force state IDLE, accumulator 0, captured operands 0, out_valid 0, prod 0, busy 0, in_ready 1 after release.
REQ-021 rst asserted mid-operation SHALL abort the operation with no out_valid pulse; first acceptance after release starts a clean operation.

Configuration
REQ-022 Macro ACCA_SKIP_ZERO_EN, when defined, SHALL skip any of LL/LH/HL/HH whose nib_a or nib_b is 0 (contribution forced to 0, nib_p ignored), going directly to the next non-skipped state or DONE; latency = 1 + active partials cycles to out_valid (minimum: acceptance then DONE next cycle when all skipped).
REQ-023 Without ACCA_SKIP_ZERO_EN, all four states SHALL always execute and nib_p SHALL be accumulated even when a nibble is 0.

Verification (bench models external unit as exact 4x4 unless stated)
REQ-024 a=0xFF, b=0xFF, out_ready=1 -> nib_sel 0,1,2,3 on consecutive cycles, out_valid 5th cycle after accept, prod=0xFE01.
REQ-025 a=0x12, b=0x34, out_ready=0 for 3 cycles in DONE -> prod=0x03A8 held stable, out_valid held, clears one cycle after out_ready=1.
REQ-026 External unit forced nib_p=0xFF always, a=b=0x11 -> prod=(0xFF+0xFF0+0xFF0+0xFF00) mod 2^16=0x1FDF.
REQ-027 rst pulsed during HL of a=0xAB, b=0xCD -> no out_valid, in_ready=1 after release; next op a=0x03,b=0x05 -> prod=0x000F.
REQ-028 a=0x0F, b=0x0F: macro off -> 4 nibble cycles, prod=0x00E1; ACCA_SKIP_ZERO_EN -> only LL executes, out_valid 2nd cycle after accept, prod=0x00E1.
REQ-029 in_valid held high with changing a/b during operation -> only first pair used; next accept occurs one cycle after result consumed.

Source files
------------

// File: rtl/acca_seq_ctrl.sv
// ---------------------------------------------------------------------------
// acca_seq_ctrl
//
// Sequences an 8x8 unsigned multiply through one shared external 4x4
// (possibly approximate) multiplier. A captured operand pair is split into
// nibbles, and the four partial products LL, LH, HL, HH are requested one per
// cycle and accumulated, with weights 1, 16, 16 and 256, into a 16-bit
// accumulator that wraps modulo 2^16. The result is held with a
// valid/ready handshake until it is consumed.
//
// Optional feature (compile-time macro):
//   ACCA_SKIP_ZERO_EN - a partial whose nibble operand A or B is zero is not
//                       visited at all. Its contribution is zero, and nib_p
//                       is never sampled for it.
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   rst        in   1   asynchronous reset, active-high
//   in_valid   in   1   operand pair offered
//   in_ready   out  1   controller is idle and accepts operands
//   a, b       in   8   multiplicand / multiplier, captured on accept
//   nib_a      out  4   nibble operand A for the external 4x4 unit
//   nib_b      out  4   nibble operand B for the external 4x4 unit
//   nib_sel    out  2   partial index (0=LL, 1=LH, 2=HL, 3=HH)
//   nib_p      in   8   same-cycle product from the external 4x4 unit
//   out_valid  out  1   result available
//   out_ready  in   1   consumer accepts the result
//   prod       out  16  accumulated product (zero outside DONE)
//   busy       out  1   controller is in any state other than IDLE
// ---------------------------------------------------------------------------
module acca_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [3:0]  nib_a,
    output logic [3:0]  nib_b,
    output logic [1:0]  nib_sel,
    input  logic [7:0]  nib_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod,
    output logic        busy
);

    // The nibble states are encoded as partial index + 1. The state after
    // nibble state S therefore starts its search at index S.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LL   = 3'd1,
        S_LH   = 3'd2,
        S_HL   = 3'd3,
        S_HH   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic        nib_state;

`ifdef ACCA_SKIP_ZERO_EN
    // Returns the first partial with index >= start whose two nibbles are
    // both non-zero. Returns DONE when no such partial remains. The loop
    // runs downward, so the lowest qualifying index is the one kept.
    function automatic state_t first_active(input logic [2:0] start,
                                            input logic [7:0] op_a,
                                            input logic [7:0] op_b);
        state_t     r;
        logic [3:0] na;
        logic [3:0] nb;
        r = S_DONE;
        for (int i = 3; i >= 0; i--) begin
            na = i[1] ? op_a[7:4] : op_a[3:0];
            nb = i[0] ? op_b[7:4] : op_b[3:0];
            if (i >= int'(start) && na != 4'h0 && nb != 4'h0) begin
                r = state_t'(3'(i + 1));
            end
        end
        return r;
    endfunction
`endif

    assign nib_state = (state_q == S_LL) || (state_q == S_LH) ||
                       (state_q == S_HL) || (state_q == S_HH);

    // State register and captured operands / accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ACCA_SKIP_ZERO_EN
                    // Decided from the incoming pair because it is only
                    // registered on this same edge.
                    state_d = first_active(3'd0, a, b);
`else
                    state_d = S_LL;
`endif
                end
            end
            S_LL, S_LH, S_HL: begin
`ifdef ACCA_SKIP_ZERO_EN
                state_d = first_active(state_q, a_q, b_q);
`else
                state_d = state_t'(state_q + 3'd1);
`endif
            end
            S_HH:    state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture and accumulation. nib_p only matters in nibble states.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (state_q == S_IDLE && in_valid) begin
            a_d   = a;
            b_d   = b;
            acc_d = 16'h0000;
        end else if (nib_state) begin
            case (state_q)
                S_LL:       acc_d = acc_q + {8'h00, nib_p};
                S_LH, S_HL: acc_d = acc_q + {4'h0, nib_p, 4'h0};
                default:    acc_d = acc_q + {nib_p, 8'h00};
            endcase
        end
    end

    // Output decode
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
        prod      = (state_q == S_DONE) ? acc_q : 16'h0000;
        nib_a     = 4'h0;
        nib_b     = 4'h0;
        nib_sel   = 2'd0;
        if (nib_state) begin
            nib_sel = 2'(state_q - 3'd1);
            nib_a   = nib_sel[1] ? a_q[7:4] : a_q[3:0];
            nib_b   = nib_sel[0] ? b_q[7:4] : b_q[3:0];
        end
    end

endmodule

// File: tb/tb_acca_seq_ctrl.sv
module tb_acca_seq_ctrl;

`ifdef ACCA_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [1:0]  nib_sel;
    logic [7:0]  nib_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] prod;
    logic        busy;
    logic        frc;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // External 4x4 unit: exact, or stuck at 0xFF when frc is set
    assign nib_p = frc ? 8'hFF : ({4'h0, nib_a} * {4'h0, nib_b});

    acca_seq_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .nib_a(nib_a), .nib_b(nib_b), .nib_sel(nib_sel),
        .nib_p(nib_p), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .busy(busy)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        frc;
        logic [15:0] p_off;
        logic [15:0] p_skip;
        int          l_off;
        int          l_skip;
        int          hold;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // One full operation: offer, accept, track the partials, hold, consume
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vf,
                          input logic [15:0] ep, input int el, input int hold,
                          input string nm);
        int          k;
        logic        seq_ok;
        logic        hold_ok;
        logic [15:0] held;
        logic [3:0]  ea;
        logic [3:0]  eb;
        @(negedge clk);
        frc = vf; a = va; b = vb; in_valid = 1'b1;
        check({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Scrambled operands after accept must not leak into the result
        in_valid = 1'b0; a = ~va; b = vb ^ 8'h5A;
        k = 0; seq_ok = 1'b1;
        while (!out_valid && k < 10) begin
            ea = nib_sel[1] ? va[7:4] : va[3:0];
            eb = nib_sel[0] ? vb[7:4] : vb[3:0];
            if (nib_a !== ea || nib_b !== eb || busy !== 1'b1) seq_ok = 1'b0;
            if (!SKIP && nib_sel !== k[1:0]) seq_ok = 1'b0;
            if (SKIP && (ea == 4'h0 || eb == 4'h0)) seq_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        check({nm, " latency"}, k, el);
        check({nm, " nibble_seq"}, {31'd0, seq_ok}, 32'd1);
        check({nm, " prod"}, {16'd0, prod}, {16'd0, ep});
        held = prod; hold_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || prod !== held) hold_ok = 1'b0;
        end
        if (hold > 0) check({nm, " hold"}, {31'd0, hold_ok}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, " out_valid_clear"}, {31'd0, out_valid}, 32'd0);
        check({nm, " idle_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int   k;
        logic nov;

        //         a      b      frc   p_off     p_skip    lo ls hold
        tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 16'hFE01, 4, 4, 0};
        tbl[1] = '{8'h12, 8'h34, 1'b0, 16'h03A8, 16'h03A8, 4, 4, 3};
        tbl[2] = '{8'h11, 8'h11, 1'b1, 16'h1FDF, 16'h1FDF, 4, 4, 0};
        tbl[3] = '{8'h0F, 8'h0F, 1'b0, 16'h00E1, 16'h00E1, 4, 1, 0};
        tbl[4] = '{8'hA0, 8'h0B, 1'b0, 16'h06E0, 16'h06E0, 4, 1, 1};
        tbl[5] = '{8'h80, 8'h01, 1'b0, 16'h0080, 16'h0080, 4, 1, 0};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 16'h1FDF, 16'h0000, 4, 0, 0};
        tbl[7] = '{8'hF0, 8'h0F, 1'b0, 16'h0E10, 16'h0E10, 4, 1, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00; frc = 1'b0;
        #12;
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst prod", {16'd0, prod}, 32'd0);
        check("rst nib_sel", {30'd0, nib_sel}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].frc,
                   SKIP ? tbl[i].p_skip : tbl[i].p_off,
                   SKIP ? tbl[i].l_skip : tbl[i].l_off,
                   tbl[i].hold, $sformatf("vec%0d", i));
        end

        // Reset in the middle of an operation (during HL)
        @(negedge clk);
        frc = 1'b0; a = 8'hAB; b = 8'hCD; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort at HL nib_sel", {30'd0, nib_sel}, 32'd2);
        rst = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        check("abort nib_sel", {30'd0, nib_sel}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nov = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) nov = 1'b0;
        end
        check("abort no out_valid", {31'd0, nov}, 32'd1);
        run_op(8'h03, 8'h05, 1'b0, 16'h000F, SKIP ? 1 : 4, 0, "after_rst");

        // in_valid held high with operands changing throughout
        @(negedge clk);
        a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 10) begin
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            k++;
        end
        check("stream first prod", {16'd0, prod}, 32'h03A8);
        check("stream first lat", k, 4);
        a = 8'h03; b = 8'h05; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("stream consume out_valid", {31'd0, out_valid}, 32'd0);
        check("stream gap busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("stream second accepted", {31'd0, busy}, 32'd1);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("stream second prod", {16'd0, prod}, 32'h000F);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stream second clear", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
